// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter and fetch-sequencing stage of a single-cycle processor.
// Holds the word-addressed PC that drives the instruction memory, and picks
// the next PC from four sources: sequential, branch, jump or jump-register.
// It also sequences the boot, halt and address-fault conditions.
//
// Parameters
//   RESET_PC    PC loaded on reset (word address)
//   ADDR_WIDTH  implemented instruction-memory index bits
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   synchronous active-low reset
//   stall            in   hold PC, state and counter this cycle (RUN only)
//   branch_taken     in   take conditional branch (pc_plus1 + branch_offset)
//   branch_offset    in   sign-extended word offset
//   jump             in   absolute jump {pc_plus1[31:26], jump_index}
//   jump_index       in   jump target field
//   jump_reg         in   register jump to jump_reg_target
//   jump_reg_target  in   register value for jump_reg
//   halt             in   current instruction is a halt
//   resume           in   leave HALTED
//   pc               out  current PC / instruction-memory address
//   pc_plus1         out  pc + 1 (link value / branch base)
//   fetch_valid      out  instruction at pc executes this cycle
//   state            out  0 BOOT, 1 RUN, 2 HALTED, 3 FAULT
//   addr_fault       out  PC left the implemented memory range
//   fetch_count      out  instructions completed since reset (saturating)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jump_reg_target,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] pc_plus1,
    output logic        fetch_valid,
    output logic [1:0]  state,
    output logic        addr_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } fetch_state_e;

    // Bits above the implemented index; any of them set means out of range.
    // With ADDR_WIDTH = 32 the shift yields 0, so the mask becomes all-zero.
    localparam logic [31:0] OOR_MASK = ~((32'd1 << ADDR_WIDTH) - 32'd1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic         addr_fault_q, addr_fault_d;

    logic [31:0]  pc_plus1_s;
    logic [31:0]  next_pc_s;
    logic         next_oor_s;

    assign pc_plus1_s = pc_q + 32'd1;

    // Next-PC selection: jump_reg > jump > branch > sequential.
    always_comb begin
        next_pc_s = pc_plus1_s;
        if (jump_reg) begin
            next_pc_s = jump_reg_target;
        end else if (jump) begin
            next_pc_s = {pc_plus1_s[31:26], jump_index};
        end else if (branch_taken) begin
            next_pc_s = pc_plus1_s + branch_offset;
        end else begin
            next_pc_s = pc_plus1_s;
        end
        next_oor_s = |(next_pc_s & OOR_MASK);
    end

    // Next-state, next-PC and counter logic for the fetch sequencer.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        addr_fault_d  = addr_fault_q;
        case (state_q)
            ST_BOOT: begin
                // RESET_PC is executed as-is; it is never range-checked here.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    pc_d = next_pc_s;
                    if (fetch_count_q != 32'hFFFF_FFFF) begin
                        fetch_count_d = fetch_count_q + 32'd1;
                    end else begin
                        fetch_count_d = fetch_count_q;
                    end
                    // Fault outranks halt when both apply in the same cycle.
                    if (next_oor_s) begin
                        state_d      = ST_FAULT;
                        addr_fault_d = 1'b1;
                    end else if (halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_FAULT: begin
                // Only reset leaves FAULT; the offending PC stays visible.
                state_d      = ST_FAULT;
                addr_fault_d = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC, fault flag and instruction counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            fetch_count_q <= 32'd0;
            addr_fault_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            addr_fault_q  <= addr_fault_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus1    = pc_plus1_s;
    assign fetch_valid = (state_q == ST_RUN);
    assign state       = state_q;
    assign addr_fault  = addr_fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jump_reg_target;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic        fetch_valid;
    logic [1:0]  state;
    logic        addr_fault;
    logic [31:0] fetch_count;

    int n_cmp;
    int n_bad;
    logic [31:0] saved_count;

    pc_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .ADDR_WIDTH (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_offset   (branch_offset),
        .jump            (jump),
        .jump_index      (jump_index),
        .jump_reg        (jump_reg),
        .jump_reg_target (jump_reg_target),
        .halt            (halt),
        .resume          (resume),
        .pc              (pc),
        .pc_plus1        (pc_plus1),
        .fetch_valid     (fetch_valid),
        .state           (state),
        .addr_fault      (addr_fault),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_offset = 32'd0;
        jump = 1'b0; jump_index = 26'd0; jump_reg = 1'b0;
        jump_reg_target = 32'd0; halt = 1'b0; resume = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step(2);
        n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc got %h exp %h", pc, 32'd0); end
        n_cmp++; if (pc_plus1 !== 32'd1) begin n_bad++; $display("FAIL reset_pc_plus1 got %h exp %h", pc_plus1, 32'd1); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d exp 0", state); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fv got %b exp 0", fetch_valid); end
        n_cmp++; if (fetch_count !== 32'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
        n_cmp++; if (addr_fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %b exp 0", addr_fault); end
        rst_n = 1'b1;
        step(1);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL boot_state got %0d exp 1", state); end
        n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL boot_pc got %h exp 0", pc); end
        n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL boot_fv got %b exp 1", fetch_valid); end
        step(4);
        n_cmp++; if (pc !== 32'd4) begin n_bad++; $display("FAIL run4_pc got %0d exp 4", pc); end
        n_cmp++; if (fetch_count !== 32'd4) begin n_bad++; $display("FAIL run4_count got %0d exp 4", fetch_count); end
    endtask

    task automatic test_priority();
        step(6);
        n_cmp++; if (pc !== 32'd10) begin n_bad++; $display("FAIL prio_start_pc got %0d exp 10", pc); end
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFB;
        jump = 1'b1; jump_index = 26'd40;
        jump_reg = 1'b1; jump_reg_target = 32'd7;
        step(1);
        n_cmp++; if (pc !== 32'd7) begin n_bad++; $display("FAIL prio_jr_pc got %0d exp 7", pc); end
        jump = 1'b0; jump_reg = 1'b0;
        step(1);
        n_cmp++; if (pc !== 32'd3) begin n_bad++; $display("FAIL prio_branch_pc got %0d exp 3", pc); end
        branch_taken = 1'b0; jump = 1'b1; jump_index = 26'd40;
        step(1);
        n_cmp++; if (pc !== 32'd40) begin n_bad++; $display("FAIL prio_jump_pc got %0d exp 40", pc); end
        n_cmp++; if (fetch_count !== 32'd13) begin n_bad++; $display("FAIL prio_count got %0d exp 13", fetch_count); end
        clear_inputs();
    endtask

    task automatic test_stall();
        jump_reg = 1'b1; jump_reg_target = 32'd20;
        step(1);
        clear_inputs();
        n_cmp++; if (pc !== 32'd20) begin n_bad++; $display("FAIL stall_start_pc got %0d exp 20", pc); end
        saved_count = fetch_count;
        stall = 1'b1; branch_taken = 1'b1; branch_offset = 32'd100;
        step(3);
        n_cmp++; if (pc !== 32'd20) begin n_bad++; $display("FAIL stall_pc got %0d exp 20", pc); end
        n_cmp++; if (fetch_count !== saved_count) begin n_bad++; $display("FAIL stall_count got %0d exp %0d", fetch_count, saved_count); end
        n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL stall_fv got %b exp 1", fetch_valid); end
        clear_inputs();
        step(1);
        n_cmp++; if (pc !== 32'd21) begin n_bad++; $display("FAIL unstall_pc got %0d exp 21", pc); end
        n_cmp++; if (fetch_count !== saved_count + 32'd1) begin n_bad++; $display("FAIL unstall_count got %0d exp %0d", fetch_count, saved_count + 32'd1); end
    endtask

    task automatic test_halt_resume();
        jump_reg = 1'b1; jump_reg_target = 32'd5;
        step(1);
        clear_inputs();
        halt = 1'b1; jump = 1'b1; jump_index = 26'd50;
        step(1);
        clear_inputs();
        n_cmp++; if (pc !== 32'd50) begin n_bad++; $display("FAIL halt_pc got %0d exp 50", pc); end
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL halt_state got %0d exp 2", state); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL halt_fv got %b exp 0", fetch_valid); end
        saved_count = fetch_count;
        stall = 1'b1; jump_reg = 1'b1; jump_reg_target = 32'd99;
        step(3);
        clear_inputs();
        n_cmp++; if (pc !== 32'd50) begin n_bad++; $display("FAIL halted_hold_pc got %0d exp 50", pc); end
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL halted_hold_state got %0d exp 2", state); end
        n_cmp++; if (fetch_count !== saved_count) begin n_bad++; $display("FAIL halted_count got %0d exp %0d", fetch_count, saved_count); end
        resume = 1'b1;
        step(1);
        clear_inputs();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL resume_state got %0d exp 1", state); end
        n_cmp++; if (pc !== 32'd50) begin n_bad++; $display("FAIL resume_pc got %0d exp 50", pc); end
        n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL resume_fv got %b exp 1", fetch_valid); end
    endtask

    task automatic test_fault();
        jump_reg = 1'b1; jump_reg_target = 32'd254;
        step(1);
        clear_inputs();
        n_cmp++; if (pc !== 32'd254) begin n_bad++; $display("FAIL fault_start_pc got %0d exp 254", pc); end
        step(1);
        n_cmp++; if (pc !== 32'd255) begin n_bad++; $display("FAIL fault_255_pc got %0d exp 255", pc); end
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL fault_255_state got %0d exp 1", state); end
        step(1);
        n_cmp++; if (pc !== 32'd256) begin n_bad++; $display("FAIL fault_pc got %0d exp 256", pc); end
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL fault_state got %0d exp 3", state); end
        n_cmp++; if (addr_fault !== 1'b1) begin n_bad++; $display("FAIL fault_flag got %b exp 1", addr_fault); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL fault_fv got %b exp 0", fetch_valid); end
        resume = 1'b1;
        step(2);
        clear_inputs();
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL fault_resume_state got %0d exp 3", state); end
        n_cmp++; if (pc !== 32'd256) begin n_bad++; $display("FAIL fault_resume_pc got %0d exp 256", pc); end
        rst_n = 1'b0;
        step(1);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL fault_rst_state got %0d exp 0", state); end
        n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL fault_rst_pc got %0d exp 0", pc); end
        n_cmp++; if (addr_fault !== 1'b0) begin n_bad++; $display("FAIL fault_rst_flag got %b exp 0", addr_fault); end
        rst_n = 1'b1;
        step(1);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL fault_reboot_state got %0d exp 1", state); end
    endtask

    task automatic test_fault_vs_halt();
        jump_reg = 1'b1; jump_reg_target = 32'h0000_0100; halt = 1'b1;
        step(1);
        clear_inputs();
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL fvh_state got %0d exp 3", state); end
        n_cmp++; if (pc !== 32'h0000_0100) begin n_bad++; $display("FAIL fvh_pc got %h exp 00000100", pc); end
        n_cmp++; if (addr_fault !== 1'b1) begin n_bad++; $display("FAIL fvh_flag got %b exp 1", addr_fault); end
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset_mid_stall();
        step(3);
        n_cmp++; if (fetch_count !== 32'd3) begin n_bad++; $display("FAIL rms_pre_count got %0d exp 3", fetch_count); end
        stall = 1'b1;
        rst_n = 1'b0;
        step(1);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rms_state got %0d exp 0", state); end
        n_cmp++; if (fetch_count !== 32'd0) begin n_bad++; $display("FAIL rms_count got %0d exp 0", fetch_count); end
        n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL rms_pc got %0d exp 0", pc); end
        rst_n = 1'b1;
        step(1);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL rms_boot_state got %0d exp 1", state); end
        step(1);
        n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL rms_stalled_pc got %0d exp 0", pc); end
        clear_inputs();
        step(1);
        n_cmp++; if (pc !== 32'd1) begin n_bad++; $display("FAIL rms_resume_pc got %0d exp 1", pc); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear_inputs();
        #2;
        test_reset();
        test_priority();
        test_stall();
        test_halt_resume();
        test_fault();
        test_fault_vs_halt();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
